// File: rtl/prism_sp_dma_tx_cookie_exec_pkg.sv
// rtl/prism_sp_dma_tx_cookie_exec_pkg.sv - shared types for the TX cookie executor
// Purpose: cookie and release record layouts, address-mode switch, FSM state type.
package prism_sp_dma_tx_cookie_exec_pkg;

  localparam bit DMA_DESC_64BITADDR = 1'b1;
  localparam int DMA_ADDR_W         = DMA_DESC_64BITADDR ? 40 : 32;
  localparam int DMA_SIZE_W         = 14;

  // Produced by the descriptor-to-cookie conversion stage.
  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;       // descriptor address, echoed on release
    logic [DMA_ADDR_W-1:0] data_addr;  // data buffer start
    logic [DMA_SIZE_W-1:0] size;       // bytes
    logic                  eof;
    logic                  nocrc;
    logic                  wrap;
  } dma_tx_cookie_t;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] addr;
    logic                  wrap;
    logic                  err;
  } dma_tx_release_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_PUSH  = 2'd2
  } exec_state_e;

endpackage

// File: rtl/prism_sp_dma_tx_release_fifo.sv
// rtl/prism_sp_dma_tx_release_fifo.sv - in-order release tracking FIFO with status fields
// Purpose: holds one record per descriptor; data mover status marks entries done in order.
// Ports: push_* write a record (push_nosts = entry needs no status), sts_* status pulse,
//        rel_* release handshake of the head, full/empty occupancy, sts_overflow sticky flag.
module prism_sp_dma_tx_release_fifo
  import prism_sp_dma_tx_cookie_exec_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            push_valid,
  input  dma_tx_release_t push_data,
  input  logic            push_nosts,
  input  logic            sts_valid,
  input  logic            sts_ok,
  output logic            rel_valid,
  input  logic            rel_ready,
  output dma_tx_release_t rel_data,
  output logic            full,
  output logic            empty,
  output logic            sts_overflow
);

  localparam int PW = $clog2(DEPTH);

  dma_tx_release_t ent [DEPTH];
  logic [DEPTH-1:0] nosts;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] ok;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             sts_hit;
  logic [PW-1:0]    sts_idx;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

  // Status pointer: oldest occupied entry still waiting for a status.
  // Scanning downward lets the entry nearest the head win.
  always_comb begin
    sts_hit = 1'b0;
    sts_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i < int'(count) && !nosts[rd_ptr + PW'(i)] && !done[rd_ptr + PW'(i)]) begin
        sts_hit = 1'b1;
        sts_idx = rd_ptr + PW'(i);
      end
    end
  end

  // A no-status head counts as done; outputs are zero when nothing is offered.
  always_comb begin
    rel_valid = !empty && (done[rd_ptr] || nosts[rd_ptr]);
    rel_data  = '0;
    if (rel_valid) begin
      rel_data.addr = ent[rd_ptr].addr;
      rel_data.wrap = ent[rd_ptr].wrap;
      rel_data.err  = ent[rd_ptr].err || !ok[rd_ptr];
    end
  end

  assign pop = rel_valid && rel_ready;

  always_ff @(posedge clock) begin
    if (push_valid) begin
      ent[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      nosts        <= '0;
      done         <= '0;
      ok           <= '0;
      sts_overflow <= 1'b0;
    end else begin
      if (push_valid) begin
        nosts[wr_ptr] <= push_nosts;
        done[wr_ptr]  <= 1'b0;
        ok[wr_ptr]    <= 1'b0;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      // The status target is never the slot being written nor the head being popped.
      if (sts_valid) begin
        if (sts_hit) begin
          done[sts_idx] <= 1'b1;
          ok[sts_idx]   <= sts_ok;
        end else begin
          sts_overflow <= 1'b1;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + {{PW{1'b0}}, push_valid} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/prism_sp_dma_tx_cookie_exec.sv
// rtl/prism_sp_dma_tx_cookie_exec.sv - splits TX cookies into aligned read commands
// Purpose: accepts cookies, issues MAX_CHUNK-aligned commands to the data mover, and
//          releases descriptors in acceptance order once their status returns.
// Ports: cookie_* input stream, cmd_* data mover commands, sts_* completion status,
//        rel_* release stream, busy = work in flight.
module prism_sp_dma_tx_cookie_exec
  import prism_sp_dma_tx_cookie_exec_pkg::*;
#(
  parameter int  ADDR_WIDTH  = 40,
  parameter int  SIZE_WIDTH  = 14,
  parameter int  MAX_CHUNK   = 256,
  parameter int  OUTSTANDING = 4,
  localparam int LEN_W       = $clog2(MAX_CHUNK) + 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cookie_valid,
  output logic                  cookie_ready,
  input  dma_tx_cookie_t        cookie_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [LEN_W-1:0]      cmd_len,
  output logic                  cmd_eof,
  output logic                  cmd_nocrc,
  output logic                  cmd_last,
  input  logic                  sts_valid,
  input  logic                  sts_ok,
  output logic                  rel_valid,
  input  logic                  rel_ready,
  output logic [ADDR_WIDTH-1:0] rel_addr,
  output logic                  rel_wrap,
  output logic                  rel_err,
  output logic                  busy
);

  localparam int OFF_W = LEN_W - 1;

  exec_state_e           state;
  logic                  ready_en;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [SIZE_WIDTH-1:0] remaining;
  logic                  eof_q;
  logic                  nocrc_q;
  logic                  wrap_q;
  logic                  zero_q;
  logic [LEN_W-1:0]      room;
  logic [LEN_W-1:0]      chunk;
  logic                  chunk_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  sts_overflow;
  dma_tx_release_t       push_data;
  dma_tx_release_t       rel_data;

  // Bytes left before the next MAX_CHUNK boundary (1..MAX_CHUNK).
  assign room       = LEN_W'(MAX_CHUNK) - LEN_W'(cur_addr[OFF_W-1:0]);
  assign chunk      = (remaining < SIZE_WIDTH'(room)) ? remaining[LEN_W-1:0] : room;
  assign chunk_last = (SIZE_WIDTH'(chunk) == remaining);

  assign cmd_valid  = (state == ST_ISSUE);
  assign cmd_addr   = cur_addr;
  assign cmd_len    = chunk;
  assign cmd_last   = cmd_valid && chunk_last;
  assign cmd_eof    = cmd_last && eof_q;
  assign cmd_nocrc  = nocrc_q;

  // ready_en keeps cookie_ready low while reset is held.
  assign cookie_ready = ready_en && (state == ST_IDLE) && !fifo_full;
  assign busy         = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      ready_en  <= 1'b0;
      addr_q    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      eof_q     <= 1'b0;
      nocrc_q   <= 1'b0;
      wrap_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (cookie_valid && cookie_ready) begin
            addr_q    <= ADDR_WIDTH'(cookie_data.addr);
            cur_addr  <= ADDR_WIDTH'(cookie_data.data_addr);
            remaining <= SIZE_WIDTH'(cookie_data.size);
            eof_q     <= cookie_data.eof;
            nocrc_q   <= cookie_data.nocrc;
            wrap_q    <= cookie_data.wrap;
            zero_q    <= (cookie_data.size == '0);
            state     <= (cookie_data.size == '0) ? ST_PUSH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(chunk);
            remaining <= remaining - SIZE_WIDTH'(chunk);
            if (chunk_last) begin
              state <= ST_PUSH;
            end
          end
        end
        ST_PUSH: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A zero-size cookie never sees a status and is always released as an error.
  always_comb begin
    push_data      = '0;
    push_data.addr = DMA_ADDR_W'(addr_q);
    push_data.wrap = wrap_q;
    push_data.err  = zero_q;
  end

  prism_sp_dma_tx_release_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_fifo (
    .clock        (clock),
    .resetn       (resetn),
    .push_valid   (state == ST_PUSH),
    .push_data    (push_data),
    .push_nosts   (zero_q),
    .sts_valid    (sts_valid),
    .sts_ok       (sts_ok),
    .rel_valid    (rel_valid),
    .rel_ready    (rel_ready),
    .rel_data     (rel_data),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .sts_overflow (sts_overflow)
  );

  assign rel_addr = ADDR_WIDTH'(rel_data.addr);
  assign rel_wrap = rel_data.wrap;
  assign rel_err  = rel_data.err;

endmodule

// File: tb/tb_prism_sp_dma_tx_cookie_exec.sv
// tb/tb_prism_sp_dma_tx_cookie_exec.sv - randomized bench with a transaction-level model
module tb_prism_sp_dma_tx_cookie_exec;
  import prism_sp_dma_tx_cookie_exec_pkg::*;

  localparam longint AMASK = (64'd1 << 40) - 1;
  localparam int     CHUNK = 256;
  localparam int     DEPTH = 4;
  localparam int     NEVER = 32'h7fffffff;

  logic           clock = 1'b0;
  logic           resetn = 1'b1;
  logic           cookie_valid, cookie_ready;
  dma_tx_cookie_t cookie_data;
  logic           cmd_valid, cmd_ready;
  logic [39:0]    cmd_addr;
  logic [8:0]     cmd_len;
  logic           cmd_eof, cmd_nocrc, cmd_last;
  logic           sts_valid, sts_ok;
  logic           rel_valid, rel_ready;
  logic [39:0]    rel_addr;
  logic           rel_wrap, rel_err, busy;

  always #5 clock = ~clock;

  prism_sp_dma_tx_cookie_exec dut (
    .clock(clock), .resetn(resetn),
    .cookie_valid(cookie_valid), .cookie_ready(cookie_ready), .cookie_data(cookie_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_eof(cmd_eof), .cmd_nocrc(cmd_nocrc), .cmd_last(cmd_last),
    .sts_valid(sts_valid), .sts_ok(sts_ok),
    .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_addr(rel_addr),
    .rel_wrap(rel_wrap), .rel_err(rel_err), .busy(busy)
  );

  typedef struct { longint addr; int len; bit last; bit eof; bit nocrc; } cmd_t;
  typedef cmd_t cmd_q_t[$];
  typedef struct { longint addr; bit wrap; bit zero; bit has_sts; bit ok; int vis; } desc_t;

  cmd_t           exp_cmd[$];
  desc_t          desc_q[$];
  dma_tx_cookie_t feed_q[$];
  bit             rel_log[$];
  int             cyc = 0, checks = 0, errors = 0, acc_count = 0;
  bit             ready_en = 0, exp_ovf = 0;
  int             cmd_pct = 100, sts_pct = 100, ok_pct = 100, rel_pct = 100;
  bit             stall_cmd = 0, stall_rel = 0;
  logic [51:0]    prev_cmd;
  logic [41:0]    prev_rel;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference chunking: cut at every CHUNK-byte address boundary.
  function automatic cmd_q_t chunks(longint a, int size, bit eof, bit nocrc);
    cmd_q_t q;
    int rem = size;
    while (rem > 0) begin
      int   room = CHUNK - int'(a % CHUNK);
      cmd_t c;
      c.len   = (rem < room) ? rem : room;
      c.addr  = a;
      c.last  = (c.len == rem);
      c.eof   = eof && c.last;
      c.nocrc = nocrc;
      q.push_back(c);
      a   = (a + c.len) & AMASK;
      rem = rem - c.len;
    end
    return q;
  endfunction

  // A descriptor sits in the tracking FIFO from its vis cycle until released.
  function automatic bit m_inflight();
    return desc_q.size() > 0 && desc_q[desc_q.size()-1].vis > cyc;
  endfunction
  function automatic int m_count();
    int n = 0;
    foreach (desc_q[i]) if (desc_q[i].vis <= cyc) n++;
    return n;
  endfunction
  function automatic bit m_ready();
    return ready_en && !m_inflight() && m_count() < DEPTH;
  endfunction
  function automatic bit m_rel();
    return desc_q.size() > 0 && desc_q[0].vis <= cyc && (desc_q[0].zero || desc_q[0].has_sts);
  endfunction
  function automatic int m_sts_target();
    foreach (desc_q[i])
      if (!desc_q[i].zero && !desc_q[i].has_sts) return (desc_q[i].vis <= cyc) ? i : -1;
    return -1;
  endfunction

  task automatic check_outputs();
    chk("cookie_ready", cookie_ready, m_ready());
    chk("busy", busy, desc_q.size() > 0);
    chk("cmd_valid", cmd_valid, exp_cmd.size() > 0);
    if (cmd_valid && exp_cmd.size() > 0) begin
      chk("cmd_addr", cmd_addr, exp_cmd[0].addr);
      chk("cmd_len", cmd_len, exp_cmd[0].len);
      chk("cmd_last", cmd_last, exp_cmd[0].last);
      chk("cmd_eof", cmd_eof, exp_cmd[0].eof);
      chk("cmd_nocrc", cmd_nocrc, exp_cmd[0].nocrc);
    end
    chk("rel_valid", rel_valid, m_rel());
    if (rel_valid && m_rel()) begin
      chk("rel_addr", rel_addr, desc_q[0].addr);
      chk("rel_wrap", rel_wrap, desc_q[0].wrap);
      chk("rel_err", rel_err, desc_q[0].zero || !desc_q[0].ok);
    end
    if (stall_cmd) chk("cmd_stable", {cmd_addr, cmd_len, cmd_eof, cmd_nocrc, cmd_last}, prev_cmd);
    if (stall_rel) chk("rel_stable", {rel_addr, rel_wrap, rel_err}, prev_rel);
    chk("sts_overflow", dut.u_fifo.sts_overflow, exp_ovf);
  endtask

  // Apply the handshakes the coming edge performs to the model, clock, then compare.
  task automatic advance();
    bit acc, chs, rhs;
    int tgt;
    int e;
    e   = cyc + 1;
    acc = cookie_valid && m_ready();
    chs = cmd_ready && exp_cmd.size() > 0;
    rhs = rel_ready && m_rel();
    stall_cmd = cmd_valid && !cmd_ready;
    prev_cmd  = {cmd_addr, cmd_len, cmd_eof, cmd_nocrc, cmd_last};
    stall_rel = rel_valid && !rel_ready;
    prev_rel  = {rel_addr, rel_wrap, rel_err};
    if (sts_valid) begin
      tgt = m_sts_target();
      if (tgt >= 0) begin
        desc_q[tgt].has_sts = 1;
        desc_q[tgt].ok      = sts_ok;
      end else exp_ovf = 1;
    end
    if (chs) begin
      if (exp_cmd[0].last) desc_q[desc_q.size()-1].vis = e + 1;
      void'(exp_cmd.pop_front());
    end
    if (rhs) begin
      rel_log.push_back(desc_q[0].zero || !desc_q[0].ok);
      void'(desc_q.pop_front());
    end
    if (acc) begin
      desc_t d;
      exp_cmd   = chunks(longint'(cookie_data.data_addr), int'(cookie_data.size),
                         cookie_data.eof, cookie_data.nocrc);
      d.addr    = longint'(cookie_data.addr);
      d.wrap    = cookie_data.wrap;
      d.zero    = (cookie_data.size == 0);
      d.has_sts = 0;
      d.ok      = 0;
      d.vis     = d.zero ? e + 1 : NEVER;
      desc_q.push_back(d);
      acc_count++;
    end
    @(posedge clock);
    cyc = e;
    if (resetn) ready_en = 1;
    #1;
    if (acc) cookie_valid = 0;
    check_outputs();
  endtask

  task automatic drive();
    int t;
    if (!cookie_valid && feed_q.size() > 0) begin
      cookie_data  = feed_q.pop_front();
      cookie_valid = 1;
    end
    cmd_ready = ($urandom_range(99) < cmd_pct);
    t = m_sts_target();
    sts_valid = 0;
    sts_ok    = 0;
    if (t >= 0 && $urandom_range(99) < sts_pct) begin
      sts_valid = 1;
      sts_ok    = ($urandom_range(99) < ok_pct);
    end
    rel_ready = ($urandom_range(99) < rel_pct);
  endtask

  task automatic step();
    drive();
    advance();
  endtask

  task automatic run_idle(int bound, string name);
    int n = 0;
    while ((feed_q.size() > 0 || cookie_valid || desc_q.size() > 0) && n < bound) begin
      step();
      n++;
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL timeout_%s: still busy after %0d cycles, required idle", name, bound);
    end
  endtask

  task automatic do_reset(int hold);
    resetn = 0;
    cookie_valid = 0; cmd_ready = 0; sts_valid = 0; sts_ok = 0; rel_ready = 0;
    exp_cmd.delete(); desc_q.delete(); feed_q.delete();
    ready_en = 0; exp_ovf = 0; stall_cmd = 0; stall_rel = 0;
    #1;
    chk("rst_cookie_ready", cookie_ready, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rel_valid", rel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_data", {cmd_addr, cmd_len, cmd_eof, cmd_nocrc, cmd_last}, 0);
    chk("rst_rel_data", {rel_addr, rel_wrap, rel_err}, 0);
    chk("rst_sts_overflow", dut.u_fifo.sts_overflow, 0);
    repeat (hold) @(posedge clock);
    #1;
    resetn = 1;
    advance();
  endtask

  function automatic dma_tx_cookie_t mk(longint da, int size, bit eof, bit nocrc,
                                        longint a, bit wrap);
    dma_tx_cookie_t c;
    c.addr = 40'(a); c.data_addr = 40'(da); c.size = 14'(size);
    c.eof = eof; c.nocrc = nocrc; c.wrap = wrap;
    return c;
  endfunction

  function automatic dma_tx_cookie_t rand_cookie();
    int     k = $urandom_range(9);
    longint da, a;
    int     sz;
    a  = {$urandom, $urandom} & AMASK;
    da = (k == 0) ? (64'hFF_FFFF_FF00 + $urandom_range(255)) : ({$urandom, $urandom} & AMASK);
    sz = (k == 1) ? 0 : (k == 2) ? 256 : $urandom_range(1, 700);
    return mk(da, sz, 1'($urandom), 1'($urandom), a, 1'($urandom));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_q_t q;
    longint pin_a[4] = '{40'h10F0, 40'h1100, 40'h1200, 40'h1300};
    int     pin_l[4] = '{16, 256, 256, 72};
    int     n, base;
    cookie_valid = 0; cookie_data = '0; cmd_ready = 0;
    sts_valid = 0; sts_ok = 0; rel_ready = 0;
    #2;
    do_reset(2);

    // Hand-computed expectations that pin the chunking model.
    q = chunks(40'h10F0, 600, 1, 0);
    chk("pin_count", q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("pin_addr", q[i].addr, pin_a[i]);
      chk("pin_len", q[i].len, pin_l[i]);
      chk("pin_last", q[i].last, i == 3);
    end
    chk("pin_eof", q[3].eof, 1);
    q = chunks(40'hFF_FFFF_FFF0, 32, 0, 1);
    chk("pin_wrap_addr", q[1].addr, 0);
    chk("pin_wrap_len", q[0].len, 16);

    // Single 64-byte frame.
    rel_log.delete();
    feed_q.push_back(mk(40'h1000, 64, 1, 0, 40'hABC0, 0));
    n = 0;
    do begin step(); n++; end while (!cmd_valid && n < 10);
    chk("a_cmd_valid", cmd_valid, 1);
    chk("a_cmd_addr", cmd_addr, 40'h1000);
    chk("a_cmd_len", cmd_len, 64);
    chk("a_cmd_last_eof", {cmd_last, cmd_eof}, 2'b11);
    run_idle(100, "single");
    chk("a_rel_count", rel_log.size(), 1);
    if (rel_log.size() == 1) chk("a_rel_err", rel_log[0], 0);

    // Unaligned 600-byte buffer.
    feed_q.push_back(mk(40'h10F0, 600, 1, 1, 40'h2220, 1));
    run_idle(100, "split");

    // Zero-size cookie queued behind a pending cookie.
    rel_log.delete();
    sts_pct = 0;
    feed_q.push_back(mk(40'h3000, 300, 0, 0, 40'h5550, 0));
    feed_q.push_back(mk(40'h4000, 0, 1, 0, 40'h5560, 1));
    repeat (20) step();
    chk("zero_waits_behind", rel_valid, 0);
    sts_pct = 100;
    run_idle(100, "zero");
    chk("zero_rel_count", rel_log.size(), 2);
    if (rel_log.size() == 2) begin
      chk("zero_rel0_err", rel_log[0], 0);
      chk("zero_rel1_err", rel_log[1], 1);
    end

    // Fill the tracking FIFO with no status returned.
    rel_log.delete();
    sts_pct = 0;
    base = acc_count;
    for (int i = 0; i < 5; i++) feed_q.push_back(mk(40'h8000 + i * 64, 8, 1, 0, 40'h100 * i, 0));
    repeat (40) step();
    chk("full_accepts", acc_count - base, 4);
    chk("full_cookie_ready", cookie_ready, 0);
    sts_pct = 100;
    run_idle(200, "full");
    chk("full_rel_count", rel_log.size(), 5);

    // Randomized traffic with back-pressure and failed statuses.
    cmd_pct = 50; sts_pct = 40; ok_pct = 70; rel_pct = 60;
    for (int i = 0; i < 30; i++) feed_q.push_back(rand_cookie());
    repeat (50) step();
    rel_pct = 0;
    repeat (10) step();
    rel_pct = 60;
    run_idle(8000, "random");

    // Reset in the middle of a 4-chunk transfer.
    cmd_pct = 100; sts_pct = 100; ok_pct = 100; rel_pct = 100;
    feed_q.push_back(mk(40'h2000, 1024, 1, 0, 40'h7770, 0));
    n = 0;
    while (exp_cmd.size() != 2 && n < 20) begin step(); n++; end
    chk("mid_cmd_valid", cmd_valid, 1);
    do_reset(1);
    feed_q.push_back(mk(40'h5040, 100, 1, 0, 40'h7780, 1));
    run_idle(100, "after_reset");

    // Status with nothing outstanding is dropped and flagged.
    sts_valid = 1; sts_ok = 1; cmd_ready = 0; rel_ready = 0;
    advance();
    sts_valid = 0;
    chk("overflow_flag", dut.u_fifo.sts_overflow, 1);
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
